// File: rtl/operand_loader.sv
// operand_loader
// Captures the switch word into NREG operand slots, one slot per debounced
// press of the load button, filling slot 0 first. Flags when every slot of
// the current sequence is filled. A debounced press of the clear button
// restarts the sequence.
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   reset      in   asynchronous active-low reset; release is synchronous to clk
//   switches   in   [SW]       switch word, sampled when a load is performed
//   btn_load   in   raw load push-button (asynchronous, bouncy, active-high)
//   btn_clear  in   raw clear push-button (asynchronous, bouncy, active-high)
//   data_out   out  [NREG*SW]  packed slots; slot i is at [i*SW +: SW]
//   slot_idx   out  [IW]       index of the next slot to be written
//   all_loaded out  high while every slot holds a value from this sequence
//   load_done  out  one-cycle pulse after the last slot is written
module operand_loader #(
    parameter int SW         = 16,
    parameter int NREG       = 3,
    parameter int DB_CYCLES  = 1000000,
    parameter int WRAP       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [SW-1:0]                             switches,
    input  logic                                      btn_load,
    input  logic                                      btn_clear,
    output logic [NREG*SW-1:0]                        data_out,
    output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] slot_idx,
    output logic                                      all_loaded,
    output logic                                      load_done
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    // The counter is compared one short of DB_CYCLES: the edge on which it
    // would reach DB_CYCLES is the edge that accepts the new level.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREG - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Bit 0 = load button, bit 1 = clear button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_load};

    // Per-button conditioning: 2-flop synchronizer, stability counter,
    // rising-edge pulse of the debounced level.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic          r_sync1;
        logic          r_sync2;
        logic          r_level;
        logic          r_level_d;
        logic          r_pulse;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_pulse   <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 != r_level) begin
                    if (r_cnt == CNT_LAST) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    // Any glitch back to the accepted level restarts the count.
                    r_cnt <= '0;
                end
                r_level_d <= r_level;
                r_pulse   <= r_level & ~r_level_d;
            end
        end

        assign w_press[gi] = r_pulse;
    end

    logic w_load_pulse;
    logic w_clr_pulse;

    assign w_load_pulse = w_press[0];
    assign w_clr_pulse  = w_press[1];

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_slot_idx;
    logic [IW-1:0]   w_idx_next;
    logic            r_all_loaded;
    logic            w_all_next;
    logic            r_load_done;
    logic            w_done_next;
    logic            w_wr_en;
    logic [IW-1:0]   w_wr_idx;
    logic            w_clr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FILL;
            r_slot_idx   <= '0;
            r_all_loaded <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_slot_idx   <= w_idx_next;
            r_all_loaded <= w_all_next;
            r_load_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_slot_idx;
        w_all_next   = r_all_loaded;
        w_done_next  = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_slot_idx;
        w_clr_data   = 1'b0;

        // Clear takes priority over a simultaneous load: nothing is written.
        if (w_clr_pulse) begin
            w_state_next = ST_FILL;
            w_idx_next   = '0;
            w_all_next   = 1'b0;
            w_clr_data   = (CLEAR_DATA != 0);
        end else if (w_load_pulse) begin
            case (r_state)
                ST_FILL: begin
                    w_wr_en = 1'b1;
                    if (r_slot_idx == IDX_LAST) begin
                        w_state_next = ST_FULL;
                        w_idx_next   = '0;
                        w_all_next   = 1'b1;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_slot_idx + IW'(1);
                    end
                end
                ST_FULL: begin
                    if (WRAP != 0) begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = '0;
                        if (NREG == 1) begin
                            // A single slot is complete again immediately.
                            w_done_next = 1'b1;
                        end else begin
                            w_state_next = ST_FILL;
                            w_idx_next   = IW'(1);
                            w_all_next   = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_FILL;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_slot
        logic [SW-1:0] r_slot;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_slot <= '0;
            end else if (w_clr_data) begin
                r_slot <= '0;
            end else if (w_wr_en && (w_wr_idx == IW'(gi))) begin
                r_slot <= switches;
            end
        end

        assign data_out[gi*SW +: SW] = r_slot;
    end

    assign slot_idx   = r_slot_idx;
    assign all_loaded = r_all_loaded;
    assign load_done  = r_load_done;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DB_CYCLES=4, SW=16, NREG=3.
// Two instances share the stimulus: dut_a (WRAP=1, CLEAR_DATA=0) and
// dut_b (WRAP=0, CLEAR_DATA=1). Expected results are pushed to a queue
// when a press is driven and popped on the edge where the write lands.
module tb_operand_loader;

    localparam int DB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic        btn_load;
    logic        btn_clear;

    logic [47:0] data_a, data_b;
    logic [1:0]  idx_a, idx_b;
    logic        all_a, all_b, done_a, done_b;

    operand_loader #(.SW(16), .NREG(3), .DB_CYCLES(DB), .WRAP(1), .CLEAR_DATA(0)) dut_a (
        .clk(clk), .reset(reset), .switches(switches),
        .btn_load(btn_load), .btn_clear(btn_clear),
        .data_out(data_a), .slot_idx(idx_a), .all_loaded(all_a), .load_done(done_a)
    );

    operand_loader #(.SW(16), .NREG(3), .DB_CYCLES(DB), .WRAP(0), .CLEAR_DATA(1)) dut_b (
        .clk(clk), .reset(reset), .switches(switches),
        .btn_load(btn_load), .btn_clear(btn_clear),
        .data_out(data_b), .slot_idx(idx_b), .all_loaded(all_b), .load_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] data_a;
        logic [1:0]  idx_a;
        logic        all_a;
        logic        done_a;
        logic [47:0] data_b;
        logic [1:0]  idx_b;
        logic        all_b;
        logic        done_b;
    } exp_t;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state per instance: 0 = WRAP1/keep-data, 1 = WRAP0/clear-data.
    logic [15:0] m_slot [2][3];
    logic [1:0]  m_idx  [2];
    logic        m_all  [2];
    logic        m_full [2];
    logic        m_done [2];

    function automatic exp_t snapshot();
        exp_t e;
        e.data_a = {m_slot[0][2], m_slot[0][1], m_slot[0][0]};
        e.idx_a  = m_idx[0];
        e.all_a  = m_all[0];
        e.done_a = m_done[0];
        e.data_b = {m_slot[1][2], m_slot[1][1], m_slot[1][0]};
        e.idx_b  = m_idx[1];
        e.all_b  = m_all[1];
        e.done_b = m_done[1];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) m_slot[k][s] = 16'h0000;
            m_idx[k] = 2'd0; m_all[k] = 1'b0; m_full[k] = 1'b0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_load(input logic [15:0] sw);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (!m_full[k]) begin
                m_slot[k][m_idx[k]] = sw;
                if (m_idx[k] == 2'd2) begin
                    m_full[k] = 1'b1; m_idx[k] = 2'd0; m_all[k] = 1'b1; m_done[k] = 1'b1;
                end else begin
                    m_idx[k] = m_idx[k] + 2'd1;
                end
            end else if (k == 0) begin
                m_slot[k][0] = sw; m_idx[k] = 2'd1; m_all[k] = 1'b0; m_full[k] = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0; m_idx[k] = 2'd0; m_all[k] = 1'b0; m_full[k] = 1'b0;
            if (k == 1) for (int s = 0; s < 3; s++) m_slot[k][s] = 16'h0000;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".data_a"}, {16'h0, data_a}, {16'h0, e.data_a});
        check({tag, ".idx_a"},  {62'h0, idx_a},  {62'h0, e.idx_a});
        check({tag, ".all_a"},  {63'h0, all_a},  {63'h0, e.all_a});
        check({tag, ".done_a"}, {63'h0, done_a}, {63'h0, e.done_a});
        check({tag, ".data_b"}, {16'h0, data_b}, {16'h0, e.data_b});
        check({tag, ".idx_b"},  {62'h0, idx_b},  {62'h0, e.idx_b});
        check({tag, ".all_b"},  {63'h0, all_b},  {63'h0, e.all_b});
        check({tag, ".done_b"}, {63'h0, done_b}, {63'h0, e.done_b});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One press held 10 cycles. Inputs change just after an edge, so the
    // next edge is edge 1 and the write must land exactly on edge DB+4.
    task automatic press(input logic ld, input logic cl, input logic [15:0] sw, input string tag);
        exp_t prev;
        exp_t e;
        prev = snapshot();
        if (cl) model_clear();
        else if (ld) model_load(sw);
        q_exp.push_back(snapshot());
        switches  = sw;
        btn_load  = ld;
        btn_clear = cl;
        tick(DB + 3);
        check({tag, ".early_data_a"}, {16'h0, data_a}, {16'h0, prev.data_a});
        check({tag, ".early_idx_a"},  {62'h0, idx_a},  {62'h0, prev.idx_a});
        check({tag, ".early_data_b"}, {16'h0, data_b}, {16'h0, prev.data_b});
        tick(1);
        if (q_exp.size() == 0) begin
            check({tag, ".queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = q_exp.pop_front();
            check_all(tag, e);
            $display("press %s ld=%0b cl=%0b sw=%h -> a=%h/%0d/%0b b=%h/%0d/%0b",
                     tag, ld, cl, sw, data_a, idx_a, all_a, data_b, idx_b, all_b);
        end
        tick(1);
        check({tag, ".done_a_low"}, {63'h0, done_a}, 64'd0);
        check({tag, ".done_b_low"}, {63'h0, done_b}, 64'd0);
        tick(1);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        tick(DB + 4);
        m_done[0] = 1'b0;
        m_done[1] = 1'b0;
        check_all({tag, ".settled"}, snapshot());
    endtask

    initial begin
        reset     = 1'b0;
        switches  = 16'h0000;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        model_reset();
        tick(3);
        reset = 1'b1;
        tick(2);
        check_all("reset", snapshot());

        // Single press, write on edge 8, one write only.
        press(1'b1, 1'b0, 16'h00AA, "first_load");

        // Bounce: never stable for DB cycles, so nothing may be written.
        btn_load = 1'b1; tick(3);
        btn_load = 1'b0; tick(1);
        btn_load = 1'b1; tick(3);
        btn_load = 1'b0; tick(12);
        check_all("bounce", snapshot());
        $display("bounce -> a=%h/%0d b=%h/%0d", data_a, idx_a, data_b, idx_b);

        // Fresh sequence of three loads.
        reset = 1'b0; tick(1); reset = 1'b1; model_reset(); tick(1);
        check_all("reset2", snapshot());
        press(1'b1, 1'b0, 16'h0001, "load1");
        press(1'b1, 1'b0, 16'h0002, "load2");
        press(1'b1, 1'b0, 16'h0003, "load3");
        check({"full", ".data_a"}, {16'h0, data_a}, 64'h0000_0003_0002_0001);

        // Load when full: dut_a wraps, dut_b ignores.
        press(1'b1, 1'b0, 16'h0004, "wrap");
        press(1'b1, 1'b0, 16'h0005, "load5");

        // Clear: dut_a keeps data, dut_b zeroes it.
        press(1'b0, 1'b1, 16'h0006, "clear");
        press(1'b1, 1'b0, 16'h0007, "load7");

        // Simultaneous load and clear: clear wins, no write.
        press(1'b1, 1'b1, 16'h0008, "both");

        // Asynchronous reset mid-debounce.
        switches = 16'h00FF;
        btn_load = 1'b1;
        tick(3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset", snapshot());
        $display("async reset -> a=%h/%0d b=%h/%0d", data_a, idx_a, data_b, idx_b);
        btn_load = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(12);
        check_all("after_release", snapshot());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Next-generation switch-capture register bank for the board-level ALU front end.
- Captures the switch word into one of NREG operand slots per debounced button press. Slots fill sequentially: for example operand A, operand B, then opcode.
- Flags when the set is complete, and supports a clear button that restarts the sequence.
- Sits between the raw board pins (switches, push-buttons) and the ALU datapath inputs.

Parameters:
- SW, 16: switch/slot width in bits (>=1).
- NREG, 3: number of operand slots (>=1).
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (>=1; 10 ms at 100 MHz).
- WRAP, 1: 1 = a load press when full restarts at slot 0; 0 = a load press when full is ignored.
- CLEAR_DATA, 0: 1 = a clear press also zeroes all slots; 0 = slot contents are kept.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- switches  in  SW  switch word, sampled directly when a load is performed.
- btn_load  in  1  raw load push-button, asynchronous, bouncy, active-high.
- btn_clear  in  1  raw clear push-button, asynchronous, bouncy, active-high.
- data_out  out  NREG*SW  packed slots; slot i occupies bits [i*SW +: SW], slot 0 in the LSBs.
- slot_idx  out  max(1,clog2(NREG))  index of the next slot to be written.
- all_loaded  out  1  high while every slot holds a value from the current sequence.
- load_done  out  1  one-cycle pulse on the cycle after the last slot is written.

Behaviour:
- Reset (reset=0, asynchronous): all slots 0, slot_idx 0, all_loaded 0, load_done 0. Synchronizers, debounced levels, counters and edge registers all clear; FSM goes to FILL. Release is synchronous to clk.
- Input conditioning, per button, identical for both:
  - 2-flop synchronizer; sync2 is its output.
  - Debounce counter: on each edge, if sync2 != db_level the counter increments, else it resets to 0. On the edge where the counter would reach DB_CYCLES, db_level takes sync2 and the counter resets to 0.
  - Edge pulse: a registered pulse, high for exactly one cycle after db_level rises 0->1. Falling edges produce nothing.
  - Latency: first edge sampling the button high = edge 1; db_level rises at edge DB_CYCLES+2; the press pulse is high after edge DB_CYCLES+3; the slot is written at edge DB_CYCLES+4.
  - Any bounce (a sync2 glitch back to db_level) restarts the count.
- FSM states: FILL (slot_idx < NREG) and FULL.
  - FILL + load pulse: slot[slot_idx] <= switches.
    - If slot_idx == NREG-1: go to FULL, slot_idx <= 0, all_loaded <= 1, and load_done pulses on the next cycle.
    - Otherwise slot_idx increments.
  - FULL + load pulse:
    - WRAP=1: slot[0] <= switches, all_loaded <= 0, slot_idx <= 1, state FILL. If NREG==1 instead: stay FULL, all_loaded stays 1, load_done pulses again.
    - WRAP=0: no change.
  - Any state + clear pulse: slot_idx <= 0, all_loaded <= 0, state FILL. Slots are zeroed only if CLEAR_DATA=1. load_done does not pulse.
  - Clear and load pulses in the same cycle: clear wins and no slot is written.
- Unwritten slots keep their previous values. data_out is always driven directly from the slot registers, with no extra latency.
- A held button yields exactly one load per press; release and re-press (each stable DB_CYCLES) are required for the next load.
- Reset asserted mid-debounce or mid-sequence: everything returns to the reset values immediately. A button still held at release produces a press only after the full DB_CYCLES qualification.

Test Plan (DB_CYCLES=4, SW=16, NREG=3 unless noted):
- Reset, then switches=16'h00AA, hold btn_load 10 cycles -> slot0=16'h00AA written exactly at edge 8; slot_idx=1; one write only; all_loaded=0.
- Bounce: btn_load high 3 cycles, low 1, high 3, low -> no write, slot_idx stays 0.
- Three presses with switches 16'h0001, 16'h0002, 16'h0003 -> data_out=48'h0003_0002_0001, all_loaded=1, load_done high exactly one cycle, slot_idx=0.
- Fourth press with switches=16'h0004:
  - WRAP=1 -> slot0=16'h0004, slot_idx=1, all_loaded=0, other slots unchanged.
  - WRAP=0 -> no change.
- After two loads, press btn_clear -> slot_idx=0, all_loaded=0.
  - CLEAR_DATA=0 -> data unchanged.
  - CLEAR_DATA=1 -> data_out=0.
- btn_load and btn_clear rising on the same cycle -> no slot written, slot_idx=0. Then assert reset=0 asynchronously mid-debounce -> all outputs 0 immediately, with no write after release.
